// File: rtl/sevseg_capture.sv
// Recovers the hex value shown on each digit of a two-digit, multiplexed,
// active-low seven-segment bus, accepting a digit only after a stable run.
module sevseg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic [1:0] an,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [1:0] vld,
    output logic       upd,
    output logic       err
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_D0   = 2'd1,
        SEL_D1   = 2'd2
    } sel_t;

    localparam logic [7:0] LP_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] LP_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] LP_BLANK = 7'b1111111;

    logic [6:0] r_seg_q;
    logic [1:0] r_an_q;
    sel_t       r_sel;
    logic [6:0] r_pat;
    logic [7:0] r_cnt;
    logic [3:0] r_hex0;
    logic [3:0] r_hex1;
    logic [1:0] r_vld;
    logic       r_upd;
    logic       r_err;

    sel_t       w_sel;
    logic       w_match;
    logic       w_accept;
    logic       w_idx;
    logic       w_legal;
    logic [3:0] w_val;
    logic [3:0] w_old_hex;
    logic [3:0] w_hex0_n;
    logic [3:0] w_hex1_n;
    logic [1:0] w_vld_n;
    logic       w_upd_n;
    logic       w_err_n;

    // Blanking (11) and overlapping enables (00) both count as no digit.
    always_comb begin
        w_sel = SEL_NONE;
        case (r_an_q)
            2'b10:   w_sel = SEL_D0;
            2'b01:   w_sel = SEL_D1;
            default: w_sel = SEL_NONE;
        endcase
    end

    assign w_idx    = (w_sel == SEL_D1);
    assign w_match  = (w_sel != SEL_NONE) && (w_sel == r_sel) && (r_seg_q == r_pat);
    assign w_accept = w_match && (r_cnt == LP_LAST);

    always_comb begin
        w_legal = 1'b1;
        w_val   = 4'h0;
        case (r_seg_q)
            7'b1000000: w_val = 4'h0;
            7'b1111001: w_val = 4'h1;
            7'b0100100: w_val = 4'h2;
            7'b0110000: w_val = 4'h3;
            7'b0011001: w_val = 4'h4;
            7'b0010010: w_val = 4'h5;
            7'b0000010: w_val = 4'h6;
            7'b1111000: w_val = 4'h7;
            7'b0000000: w_val = 4'h8;
            7'b0010000: w_val = 4'h9;
            7'b0001000: w_val = 4'hA;
            7'b0000011: w_val = 4'hB;
            7'b1000110: w_val = 4'hC;
            7'b0100001: w_val = 4'hD;
            7'b0000110: w_val = 4'hE;
            7'b0001110: w_val = 4'hF;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_hex0_n  = r_hex0;
        w_hex1_n  = r_hex1;
        w_vld_n   = r_vld;
        w_upd_n   = 1'b0;
        w_err_n   = 1'b0;
        w_old_hex = w_idx ? r_hex1 : r_hex0;
        if (w_accept) begin
            if (w_legal) begin
                if (w_idx) w_hex1_n = w_val;
                else       w_hex0_n = w_val;
                w_vld_n[w_idx] = 1'b1;
                w_upd_n = (w_old_hex != w_val) || !r_vld[w_idx];
            end else if (r_seg_q == LP_BLANK) begin
                // A dark digit drops its valid bit but keeps the last value.
                w_vld_n[w_idx] = 1'b0;
                w_upd_n = r_vld[w_idx];
            end else begin
                w_err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_q <= LP_BLANK;
            r_an_q  <= 2'b11;
            r_sel   <= SEL_NONE;
            r_pat   <= LP_BLANK;
            r_cnt   <= 8'd0;
            r_hex0  <= 4'h0;
            r_hex1  <= 4'h0;
            r_vld   <= 2'b00;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_seg_q <= seg;
            r_an_q  <= an;
            if (w_match) begin
                if (r_cnt != LP_MAX) r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= (w_sel == SEL_NONE) ? 8'd0 : 8'd1;
                r_sel <= w_sel;
                r_pat <= r_seg_q;
            end
            r_hex0 <= w_hex0_n;
            r_hex1 <= w_hex1_n;
            r_vld  <= w_vld_n;
            r_upd  <= w_upd_n;
            r_err  <= w_err_n;
        end
    end

    assign hex0 = r_hex0;
    assign hex1 = r_hex1;
    assign vld  = r_vld;
    assign upd  = r_upd;
    assign err  = r_err;

endmodule
